// File: rtl/interval_event_timer_pkg.sv
// interval_event_timer_pkg: shared state encoding and snapshot layout for the interval timer
package interval_event_timer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;
    localparam int CW_DEF   = 16;
    localparam int ENTRY_W  = CW_DEF + 1;
    localparam int WRAP_BIT = CW_DEF;
endpackage

// File: rtl/interval_event_timer_snap_fifo.sv
// snap_fifo: register-array show-ahead FIFO holding measurement snapshots
module snap_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    // a full FIFO still accepts a push when the same cycle frees a slot
    always_comb begin
        empty   = level == '0;
        full    = level == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rptr];
    end
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset; only entries behind the pointers are ever read
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/interval_event_timer.sv
// interval_event_timer: start/stop control of an external event counter and snapshot capture
module interval_event_timer
    import interval_event_timer_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     evt,
    output logic                     counter_clr,
    output logic                     counter_en,
    input  logic [CW-1:0]            count_in,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [CW:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     ovf,
    input  logic                     ovf_clr
);
    state_t state;
    logic wrap, push, pop, full, empty;
    // counter controls and FIFO handshakes decoded from registered state
    always_comb begin
        counter_clr = state == CLEAR;
        counter_en  = evt && state == RUN;
        busy        = state != IDLE;
        push        = state == DRAIN;
        rd_valid    = !empty;
        pop         = rd_req && rd_valid;
    end
    // measurement sequencer and sticky wrap flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            wrap  <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (start) state <= CLEAR;
                CLEAR: begin
                    wrap  <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    if (counter_en && &count_in) wrap <= 1'b1;
                    if (stop) state <= DRAIN;
                end
                DRAIN: state <= IDLE;
            endcase
        end
    end
    // a drop sets ovf even when software clears it in the same cycle
    always_ff @(posedge clock) begin
        if (!reset) ovf <= 1'b0;
        else ovf <= (push && full && !pop) || (ovf && !ovf_clr);
    end
    snap_fifo #(.DEPTH(DEPTH), .W(CW + 1)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wrap, count_in}),
        .dout  (rd_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_interval_event_timer.sv
// tb_interval_event_timer: random and directed checks against a queue-based reference model
module tb_interval_event_timer;
    localparam int DEPTH = 4;
    logic clock = 0, reset = 0, start = 0, stop = 0, evt = 0, rd_req = 0, ovf_clr = 0;
    logic counter_clr, counter_en, rd_valid, busy, ovf;
    logic [15:0] count_in;
    logic [16:0] rd_data;
    logic [2:0] level;
    logic pre_en = 0;
    logic [15:0] pre_val = 0;
    int nerr = 0, nchk = 0;
    logic [16:0] q[$];
    bit ovf_m = 0;

    interval_event_timer #(.CW(16), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop), .evt(evt),
        .counter_clr(counter_clr), .counter_en(counter_en), .count_in(count_in),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
        .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clock = ~clock;

    // registered counter model: clear beats preload beats enable
    always @(posedge clock) begin
        if (counter_clr) count_in <= '0;
        else if (pre_en) count_in <= pre_val;
        else if (counter_en) count_in <= count_in + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [16:0] snap(input int total);
        return {total >= 65536, 16'(total % 65536)};
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(q.size()));
        chk({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
        chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_m));
        if (q.size() != 0) chk({tag, "_head"}, 32'(rd_data), 32'(q[0]));
    endtask

    task automatic drain_one();
        rd_req = 1;
        if (q.size() != 0) chk("rd_head", 32'(rd_data), 32'(q[0]));
        tick();
        rd_req = 0;
        if (q.size() != 0) q.delete(0);
        chk_state("after_rd");
    endtask

    task automatic clear_ovf();
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        ovf_m = 0;
        chk("ovf_clr", 32'(ovf), 0);
    endtask

    task automatic measure(input int nev, input int pre, input bit stop_evt, input bit pop_dr, input bit clr_dr);
        bit popped, drop;
        start = 1;
        tick();
        start = 0;
        chk("clr_in_clear", 32'(counter_clr), 1);
        chk("busy_clear", 32'(busy), 1);
        tick();
        chk("clr_off_run", 32'(counter_clr), 0);
        if (pre != 0) begin
            pre_val = 16'(pre);
            pre_en = 1;
            tick();
            pre_en = 0;
        end
        for (int i = 0; i < nev; i++) begin
            evt = 1;
            stop = stop_evt && i == nev - 1;
            start = $urandom_range(0, 7) == 0;
            tick();
            evt = 0;
            stop = 0;
            start = 0;
            if (nev < 50 && i < nev - 1 && $urandom_range(0, 3) == 0) tick();
        end
        if (!(stop_evt && nev > 0)) begin
            stop = 1;
            tick();
            stop = 0;
        end
        chk("busy_drain", 32'(busy), 1);
        evt = 1'($urandom_range(0, 1));
        rd_req = pop_dr;
        ovf_clr = clr_dr;
        #1;
        chk("en_drain", 32'(counter_en), 0);
        if (pop_dr && q.size() != 0) chk("head_drain", 32'(rd_data), 32'(q[0]));
        tick();
        rd_req = 0;
        ovf_clr = 0;
        evt = 0;
        popped = pop_dr && q.size() != 0;
        if (popped) q.delete(0);
        drop = q.size() == DEPTH;
        if (!drop) q.push_back(snap(pre + nev));
        ovf_m = drop || (ovf_m && !clr_dr);
        chk("busy_idle", 32'(busy), 0);
        chk_state("meas");
    endtask

    initial begin
        tick();
        chk("rst_clr", 32'(counter_clr), 0);
        chk("rst_en", 32'(counter_en), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        tick();
        reset = 1;
        tick();
        stop = 1;
        tick();
        stop = 0;
        chk("stop_in_idle", 32'(busy), 0);

        measure(5, 0, 0, 0, 0);
        chk("basic", 32'(rd_data), 32'h0_0005);
        chk("basic_level", 32'(level), 1);
        drain_one();
        chk("basic_empty", 32'(rd_valid), 0);

        measure(4, 0, 1, 0, 0);
        chk("stop_evt", 32'(rd_data), 32'h0_0004);
        drain_one();
        drain_one();

        for (int i = 1; i <= 5; i++) measure(i, 0, 0, 0, 0);
        chk("full_level", 32'(level), 4);
        chk("full_ovf", 32'(ovf), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("full_rd", 32'(rd_data), 32'(i));
            drain_one();
        end
        clear_ovf();

        for (int i = 6; i <= 9; i++) measure(i, 0, 0, 0, 0);
        measure(10, 0, 0, 1, 0);
        chk("pp_ovf", 32'(ovf), 0);
        chk("pp_level", 32'(level), 4);
        for (int i = 7; i <= 10; i++) begin
            chk("pp_rd", 32'(rd_data), 32'(i));
            drain_one();
        end

        measure(1, 0, 0, 0, 0);
        measure(1, 0, 0, 0, 0);
        measure(1, 0, 0, 0, 0);
        measure(1, 0, 0, 0, 0);
        measure(1, 0, 0, 0, 1);
        chk("drop_and_clr", 32'(ovf), 1);
        clear_ovf();
        repeat (4) drain_one();

        start = 1;
        tick();
        start = 0;
        tick();
        repeat (3) begin
            evt = 1;
            tick();
        end
        evt = 0;
        reset = 0;
        tick();
        reset = 1;
        q.delete();
        ovf_m = 0;
        evt = 1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_en", 32'(counter_en), 0);
        evt = 0;
        measure(2, 0, 0, 0, 0);
        chk("after_rst", 32'(rd_data), 32'h0_0002);
        drain_one();

        measure(65537, 0, 0, 0, 0);
        chk("wrap", 32'(rd_data), 32'h1_0001);
        drain_one();
        measure(15, 16'hFFF0, 0, 0, 0);
        chk("no_wrap", 32'(rd_data), 32'h0_FFFF);
        drain_one();
        measure(17, 16'hFFF0, 1, 0, 0);
        chk("wrap_pre", 32'(rd_data), 32'h1_0001);
        drain_one();

        for (int n = 0; n < 40; n++) begin
            measure(int'($urandom_range(0, 12)), ($urandom_range(0, 4) == 0) ? 16'hFFF8 : 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) drain_one();
            if ($urandom_range(0, 5) == 0) clear_ovf();
        end
        while (q.size() != 0) drain_one();
        drain_one();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/interval_event_timer.md
# interval_event_timer

Control-and-capture stage wrapped around the 16-bit event counter, sitting on both sides of it.
- Upstream: drives the counter's clear and enable inputs from start/stop commands and a qualified event strobe.
- Downstream: captures the counter output at the end of each measurement into a small show-ahead snapshot FIFO that the processor drains through a valid/request read port.

## Interface
Parameters:
- CW, 16: counter width; must match the counter's output width.
- DEPTH, 4: snapshot FIFO entries; power of two, ≥2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clock.
- start  in  1  single-cycle request to begin a measurement.
- stop  in  1  single-cycle request to end a measurement.
- evt  in  1  event strobe; counted once per cycle while running.
- counter_clr  out  1  active-high synchronous clear to counter's reset input.
- counter_en  out  1  increment enable to counter.
- count_in  in  CW  counter output; registered, reflects enable one cycle later.
- rd_req  in  1  pop head entry; honoured only when rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  CW+1  head entry {wrap, count}; valid while rd_valid=1.
- level  out  log2(DEPTH)+1  entries held.
- busy  out  1  state ≠ IDLE.
- ovf  out  1  sticky: snapshot dropped because FIFO full.
- ovf_clr  in  1  clears ovf.

## Operation
- FSM states IDLE, CLEAR, RUN, DRAIN.
- IDLE: start → CLEAR; stop ignored.
- CLEAR: counter_clr=1, counter_en=0, wrap flag cleared; always → RUN next cycle.
- RUN: counter_en=evt, including the cycle stop is seen. stop → DRAIN; start ignored.
- Wrap: in RUN, if counter_en=1 and count_in=all-ones, set wrap flag (count rolls to 0). Wrap is sticky for the measurement.
- DRAIN: counter_en=0. count_in already includes the stop-cycle increment. Push {wrap, count_in} → IDLE.
- start and stop in the same cycle: IDLE takes start; RUN takes stop.
- counter_clr=1 only in CLEAR. counter_en=0 outside RUN.

FIFO behaviour:
- rd_data is the head entry combinationally (show-ahead).
- Pop occurs on rd_req & rd_valid. rd_req while empty is ignored.
- Push when full without a same-cycle pop: entry dropped, ovf←1.
- Push and pop in the same cycle: both happen; level unchanged. This includes the full case, where no drop occurs.
- ovf_clr and a drop in the same cycle: ovf ends at 1.
- Pointers wrap modulo DEPTH. level saturates logically at DEPTH and never exceeds it.

Reset (reset=0 at an edge), in any state including mid-RUN or mid-DRAIN:
- State → IDLE; the in-flight measurement is discarded and not pushed.
- FIFO emptied; wrap=0, ovf=0.
- After the edge: counter_clr=0, counter_en=0, rd_valid=0, level=0, busy=0, ovf=0. rd_data is don't-care.

## Timing
- start at cycle T: CLEAR at T+1, RUN from T+2. First countable evt is at T+2.
- stop at cycle S in RUN: DRAIN at S+1, entry visible (rd_valid=1) at S+2.
- Minimum start-to-start interval for back-to-back measurements: stop at S, start accepted at S+2.
- Pop at cycle P: new head/level visible at P+1.
- All outputs are registered or decoded from registered state. No combinational path from start/stop/evt to counter_clr, counter_en, or FIFO flags.
- Exception: counter_en = evt & (state==RUN) is combinational by design.

## Structure
- Shared package holds:
  - the state enumeration (2-bit: IDLE=0, CLEAR=1, RUN=2, DRAIN=3)
  - the CW default
  - the snapshot entry width (CW+1)
  - the wrap-bit index (CW)
- Sub-module snap_fifo(DEPTH, W): register-array FIFO with push, pop, show-ahead head, level, full, and empty. The top level holds the FSM, wrap flag, and ovf.
- The counter itself is instantiated beside this block, not inside it.

## Test plan
Bench models the counter: registered, clear has priority over enable.
- Basic: start; 5 evt pulses in RUN; stop → rd_valid at stop+2, rd_data=17'h0_0005, level=1. Then rd_req → rd_valid=0.
- Stop-cycle event: evt=1 on the same cycle as stop, with 3 earlier events → rd_data=17'h0_0004.
- Wrap: 65 537 events → rd_data=17'h1_0001. With 65 535 events → 17'h0_FFFF.
- FIFO full: 5 measurements of 1,2,3,4,5 events, no reads → level=4, ovf=1; reads return 1,2,3,4. ovf_clr → ovf=0.
- Push/pop when full: FIFO full, rd_req asserted in the DRAIN cycle → no drop, ovf=0, level stays 4, new tail=new count.
- Reset mid-RUN: reset=0 for 1 cycle after 3 events → busy=0, level=0, counter_en=0. Next measurement of 2 events → 17'h0_0002.
